// File: rtl/edge_counter_pkg.sv
// Shared mode encodings and parameter range limits for the edge counter bank.
package edge_counter_pkg;

  localparam int MODE_WRAP    = 0;
  localparam int MODE_SAT     = 1;

  localparam int WIDTH_MIN    = 1;
  localparam int WIDTH_MAX    = 16;
  localparam int CHANNELS_MIN = 1;
  localparam int CHANNELS_MAX = 8;

endpackage

// File: rtl/edge_counter_chan.sv
// One counter lane: event qualification, up/down count against a shared limit,
// wrap-or-saturate behaviour and a one-cycle terminal-count pulse.
module edge_counter_chan
  import edge_counter_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int SATURATE = MODE_WRAP,
  parameter int EDGE     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             hit,
  output logic             hit_nxt
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic             en_q;
  logic             evt;
  logic [WIDTH-1:0] count_p0;
  logic             hit_p0;
  logic [WIDTH-1:0] cnt_nxt;

  // Returns {hit, count} for an up event; counts at or past limit fall back.
  function automatic logic [WIDTH:0] step_up(input logic [WIDTH-1:0] c,
                                             input logic [WIDTH-1:0] l);
    logic [WIDTH-1:0] inc;
    inc = c + ONE;
    if (c < l)
      step_up = {(inc == l), inc};
    else if (SATURATE == MODE_SAT)
      step_up = {1'b0, l};
    else
      step_up = {1'b0, ZERO};
  endfunction

  function automatic logic [WIDTH:0] step_down(input logic [WIDTH-1:0] c,
                                               input logic [WIDTH-1:0] l);
    if (c != ZERO)
      step_down = {1'b0, c - ONE};
    else if (SATURATE == MODE_SAT)
      step_down = {1'b0, ZERO};
    else
      step_down = {1'b1, l};
  endfunction

  assign evt = (EDGE != 0) ? (en & ~en_q) : en;

  always_comb begin
    cnt_nxt = count_p0;
    hit_nxt = 1'b0;
    if (rst || clr) begin
      cnt_nxt = ZERO;
      hit_nxt = 1'b0;
    end else if (evt) begin
      if (dir)
        {hit_nxt, cnt_nxt} = step_up(count_p0, limit);
      else
        {hit_nxt, cnt_nxt} = step_down(count_p0, limit);
    end
  end

  // Stage p0: single register stage; en_q tracks en even during reset and clear
  // so a level held across either is not seen as a fresh edge.
  always_ff @(posedge clk) begin
    en_q     <= en;
    count_p0 <= cnt_nxt;
    hit_p0   <= hit_nxt;
  end

  assign count = count_p0;
  assign hit   = hit_p0;

endmodule

// File: rtl/edge_counter_bank.sv
// Bank of CHANNELS independent edge/level counters sharing one terminal value,
// with a registered OR of all terminal-count pulses.
module edge_counter_bank
  import edge_counter_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 2,
  parameter int SATURATE = MODE_WRAP,
  parameter int EDGE     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [WIDTH-1:0]          limit,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       hit,
  output logic                      any_hit
);

  logic [CHANNELS-1:0] hit_nxt;
  logic                any_hit_p0;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_counter_chan #(
      .WIDTH   (WIDTH),
      .SATURATE(SATURATE),
      .EDGE    (EDGE)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en[i]),
      .dir    (dir[i]),
      .clr    (clr[i]),
      .limit  (limit),
      .count  (count[i*WIDTH +: WIDTH]),
      .hit    (hit[i]),
      .hit_nxt(hit_nxt[i])
    );
  end

  // Stage p0: any_hit registered from the lanes' next-state hits so it rises
  // in the same cycle as the individual pulses.
  always_ff @(posedge clk) begin
    if (rst)
      any_hit_p0 <= 1'b0;
    else
      any_hit_p0 <= |hit_nxt;
  end

  assign any_hit = any_hit_p0;

endmodule

// File: doc/edge_counter_bank.md
# edge_counter_bank

Parametrised bank of independent edge/level counters with a programmable terminal value, per-channel direction, clear, wrap-or-saturate mode and a one-cycle terminal-count pulse. It generalises the single fixed 5-bit counter with a status output to CHANNELS lanes of WIDTH bits, adding down-counting, a runtime limit, and edge qualification. It sits between raw stimulus/event inputs and the status logic that consumes terminal-count flags.

## Interface
- WIDTH, 5: counter width per channel, 1..16.
- CHANNELS, 2: number of independent lanes, 1..8.
- SATURATE, 0: 0 = wrap at limit/zero; 1 = hold at limit/zero.
- EDGE, 1: 1 = count rising edges of `en`; 0 = count every cycle `en` is high.

- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  CHANNELS  per-lane count event input.
- dir  in  CHANNELS  per-lane direction, 1 = up, 0 = down.
- clr  in  CHANNELS  per-lane synchronous clear.
- limit  in  WIDTH  shared terminal value, sampled every cycle.
- count  out  CHANNELS*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
- hit  out  CHANNELS  one-cycle terminal-count pulse per lane.
- any_hit  out  1  OR of `hit` (registered with `hit`, same cycle).

## Operation
- Event per lane: EDGE=1 → `en & ~en_q`; EDGE=0 → `en`. `en_q` is a per-lane register of `en`.
- Priority per lane: rst > clr > event > hold.
- clr: count ← 0, hit ← 0; `en_q` still updates (an edge coincident with clr is consumed, not counted).
- Up event, count < limit: count ← count+1; hit ← 1 if count+1 == limit.
- Up event, count ≥ limit: wrap mode → count ← 0, hit ← 0; saturate → count ← limit, hit ← 0.
- Down event, count > 0: count ← count−1, hit ← 0.
- Down event, count == 0: wrap → count ← limit, hit ← 1; saturate → count stays 0, hit ← 0.
- limit == 0: up events in wrap mode keep count 0 with no hit; down events in wrap mode keep 0 and pulse hit.
- Arithmetic is WIDTH bits unsigned; no carry out; limit ≥ 2^WIDTH unrepresentable by construction.
- Lanes fully independent; simultaneous events on all lanes each apply in the same cycle.
- limit change takes effect on the next event; no retroactive clamp.

## Timing
- Reset: count = 0, hit = 0, any_hit = 0; during rst `en_q` ← `en` so an `en` held high across reset release produces no event.
- Latency: `en` rise sampled at edge k → count and hit updated at edge k (visible cycle k+1); one register stage, no combinational input-to-output path.
- hit is high for exactly one cycle per qualifying event; consecutive qualifying events give consecutive pulses.
- EDGE=1: `en` held high N cycles counts once; re-arm requires one low sample.
- rst asserted mid-count: state cleared at that edge regardless of en/clr.

## Structure
- Package `edge_counter_pkg`: localparams for mode encodings (MODE_WRAP, MODE_SAT) and parameter range limits.
- Sub-module `edge_counter_chan`: one lane (en_q, count, hit), WIDTH/SATURATE/EDGE parameters; top instantiates CHANNELS copies in a generate loop and forms `any_hit`.

## Test plan
- Reset release with en[0]=1 held, WIDTH=5: count stays 0, no hit for 10 cycles.
- EDGE=1, wrap, limit=5, 6 rising edges on en[0], dir=1: count 1,2,3,4,5,0; hit pulses once, in the cycle count becomes 5.
- SATURATE=1, limit=3, lane 1 down from 0 then up 5 events: count stays 0, then 1,2,3,3,3; single hit at 3.
- Wrap, dir=0, count=0, limit=31: one event → count=31, hit=1 for one cycle.
- clr[0] and en[0] rise together at count=4: count=0, hit=0, next en rise → count=1.
- CHANNELS=4, EDGE=0, all en high 7 cycles, limit=7: every lane reaches 7, hit=4'hF and any_hit=1 in the same single cycle.
